// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the phase type used by the
// horizontal and vertical trackers.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
   localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

   typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} vga_phase_t;

endpackage

// File: rtl/vga_timing_gen_delay.sv
// Tick-enabled shift register that lines sync/blank up with the
// video generator's pipeline. DEPTH=0 is a straight pass-through.
module sync_delay_line #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, rst_n, en};
      assign q = d;
   end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // shift one stage per enable; reset fills every stage with RST_VAL
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
         end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
         end
      end

      assign q = stage[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe, x/y counters, phase trackers and
// the delayed sync/blank outputs for the DAC.
//
// state     | meaning
// PH_ACTIVE | visible pixels / lines
// PH_FRONT  | front porch
// PH_SYNC   | sync pulse asserted
// PH_BACK   | back porch
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int PIPE_DLY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_en,
   output logic       vga_clk,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       sync_n,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] H_FP_LAST  = 10'(H_ACTIVE + H_FP - 1);
   localparam logic [9:0] H_SY_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
   localparam logic [9:0] V_FP_LAST  = 10'(V_ACTIVE + V_FP - 1);
   localparam logic [9:0] V_SY_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
      $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
   end
   if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_dly_chk
      $fatal(1, "vga_timing_gen: PIPE_DLY must be 0..7");
   end

   logic       tick;
   logic       x_wrap;
   logic       y_wrap;
   logic       primed;
   logic       h_vis;
   logic       v_vis;
   logic       hs_head;
   logic       vs_head;
   logic [2:0] head;
   vga_phase_t h_phase;
   vga_phase_t v_phase;

   assign tick   = pix_en;
   assign x_wrap = (x == H_LAST);
   assign y_wrap = (y == V_LAST);
   assign sync_n = 1'b0;
   assign active = h_vis & v_vis;

   // pixel strobe at half clk rate; DAC clock trails it by one clk
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_en  <= 1'b0;
         vga_clk <= 1'b0;
      end else begin
         pix_en  <= ~pix_en;
         vga_clk <= pix_en;
      end
   end

   // raster counters; primed masks blank_n until the first tick after reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x      <= '0;
         y      <= '0;
         primed <= 1'b0;
      end else if (tick) begin
         primed <= 1'b1;
         x      <= x_wrap ? '0 : x + 10'd1;
         if (x_wrap) y <= y_wrap ? '0 : y + 10'd1;
      end
   end

   // H/V phase trackers; visibility and sync heads are registered on entry to each phase
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_phase <= PH_ACTIVE;
         v_phase <= PH_ACTIVE;
         h_vis   <= 1'b1;
         v_vis   <= 1'b1;
         hs_head <= ~SYNC_POL;
         vs_head <= ~SYNC_POL;
      end else if (tick) begin
         case (h_phase)
            PH_ACTIVE: if (x == H_ACT_LAST) begin h_phase <= PH_FRONT;  h_vis   <= 1'b0;      end
            PH_FRONT:  if (x == H_FP_LAST)  begin h_phase <= PH_SYNC;   hs_head <= SYNC_POL;  end
            PH_SYNC:   if (x == H_SY_LAST)  begin h_phase <= PH_BACK;   hs_head <= ~SYNC_POL; end
            PH_BACK:   if (x_wrap)          begin h_phase <= PH_ACTIVE; h_vis   <= 1'b1;      end
            default:                        h_phase <= PH_ACTIVE;
         endcase
         if (x_wrap) begin
            case (v_phase)
               PH_ACTIVE: if (y == V_ACT_LAST) begin v_phase <= PH_FRONT;  v_vis   <= 1'b0;      end
               PH_FRONT:  if (y == V_FP_LAST)  begin v_phase <= PH_SYNC;   vs_head <= SYNC_POL;  end
               PH_SYNC:   if (y == V_SY_LAST)  begin v_phase <= PH_BACK;   vs_head <= ~SYNC_POL; end
               PH_BACK:   if (y_wrap)          begin v_phase <= PH_ACTIVE; v_vis   <= 1'b1;      end
               default:                        v_phase <= PH_ACTIVE;
            endcase
         end
      end
   end

   // one-clk marker following the tick that wraps the raster to (0,0)
   always_ff @(posedge clk) begin
      if (!rst_n) frame_start <= 1'b0;
      else        frame_start <= tick & x_wrap & y_wrap;
   end

   assign head = {hs_head, vs_head, active & primed};

   sync_delay_line #(
      .WIDTH   (3),
      .DEPTH   (PIPE_DLY),
      .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
   ) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tick),
      .d     (head),
      .q     ({hsync, vsync, blank_n})
   );

endmodule
